// File: rtl/router_pkg.sv
// Shared state encoding and default sizing for the packet router control FSM.
package router_pkg;

    localparam int DEF_NUM_CH   = 3;
    localparam int DEF_ADDR_W   = 2;
    localparam int DEF_WAIT_TMO = 32;
    localparam int DEF_DCNT_W   = 8;

    typedef enum logic [3:0] {
        ST_DECODE          = 4'd0,
        ST_WAIT_EMPTY      = 4'd1,
        ST_LOAD_FIRST      = 4'd2,
        ST_LOAD_DATA       = 4'd3,
        ST_LOAD_PARITY     = 4'd4,
        ST_FIFO_FULL       = 4'd5,
        ST_LOAD_AFTER_FULL = 4'd6,
        ST_CHECK_PARITY    = 4'd7,
        ST_DROP            = 4'd8
    } state_t;

    // Counter width able to hold 0..tmo-1, never narrower than one bit.
    function automatic int tmo_width(input int tmo);
        return (tmo > 1) ? $clog2(tmo) : 1;
    endfunction

endpackage

// File: rtl/router_tmo_cnt.sv
// Wait-for-empty timeout counter: clears on load, counts while enabled, flags the last cycle.
module router_tmo_cnt #(
    parameter int LIMIT = 32,
    parameter int CW    = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count;

    // Holds at LAST so a stalled FSM can never wrap back into a fresh window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && count != LAST)
            count <= count + CW'(1);
    end

    assign expire = (count == LAST);

endmodule

// File: rtl/router_fsm_n.sv
// Router control FSM for NUM_CH output channels with wait timeout and packet drop accounting.
module router_fsm_n
    import router_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int WAIT_TMO = DEF_WAIT_TMO,
    parameter int DCNT_W   = DEF_DCNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              packet_valid,
    input  logic [ADDR_W-1:0] datain,
    input  logic              fifo_full,
    input  logic [NUM_CH-1:0] fifo_empty,
    input  logic [NUM_CH-1:0] soft_reset,
    input  logic              parity_done,
    input  logic              low_packet_valid,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              write_enb_reg,
    output logic              rst_int_reg,
    output logic              busy,
    output logic              drop_state,
    output logic              drop_pulse,
    output logic [ADDR_W-1:0] sel_ch,
    output logic [NUM_CH-1:0] write_sel,
    output logic [DCNT_W-1:0] drop_cnt
);

    localparam int CW = tmo_width(WAIT_TMO);
    localparam int PW = 2 ** ADDR_W;

    state_t state, next;

    // Pad per-channel vectors to the full address space so any address indexes safely.
    logic [PW-1:0] empty_pad, srst_pad;
    logic          hdr_ok, hdr_empty, sel_empty, sel_srst;
    logic          tmo_clear, tmo_en, tmo_exp, ch_active;

    assign empty_pad = PW'(fifo_empty);
    assign srst_pad  = PW'(soft_reset);
    assign hdr_ok    = 32'(datain) < NUM_CH;
    assign hdr_empty = empty_pad[datain];
    assign sel_empty = empty_pad[sel_ch];
    assign sel_srst  = srst_pad[sel_ch];

    always_comb begin
        next = state;
        case (state)
            ST_DECODE: begin
                if (packet_valid) begin
                    if (!hdr_ok)        next = ST_DROP;
                    else if (hdr_empty) next = ST_LOAD_FIRST;
                    else                next = ST_WAIT_EMPTY;
                end
            end
            ST_WAIT_EMPTY: begin
                if (sel_empty)    next = ST_LOAD_FIRST;
                else if (tmo_exp) next = ST_DROP;
            end
            ST_LOAD_FIRST: next = ST_LOAD_DATA;
            ST_LOAD_DATA: begin
                if (fifo_full)          next = ST_FIFO_FULL;
                else if (!packet_valid) next = ST_LOAD_PARITY;
            end
            ST_FIFO_FULL: begin
                if (!fifo_full) next = ST_LOAD_AFTER_FULL;
            end
            ST_LOAD_AFTER_FULL: begin
                if (parity_done)           next = ST_DECODE;
                else if (low_packet_valid) next = ST_LOAD_PARITY;
                else                       next = ST_LOAD_DATA;
            end
            ST_LOAD_PARITY:  next = ST_CHECK_PARITY;
            ST_CHECK_PARITY: next = fifo_full ? ST_FIFO_FULL : ST_DECODE;
            ST_DROP: begin
                if (!packet_valid) next = ST_DECODE;
            end
            default: next = ST_DECODE;
        endcase
        // Channel soft reset aborts whatever the packet was doing.
        if (state != ST_DECODE && sel_srst)
            next = ST_DECODE;
    end

    assign tmo_clear = (next == ST_WAIT_EMPTY) && (state != ST_WAIT_EMPTY);
    assign tmo_en    = (state == ST_WAIT_EMPTY);

    router_tmo_cnt #(
        .LIMIT(WAIT_TMO),
        .CW   (CW)
    ) u_tmo (
        .clk   (clk),
        .reset (reset),
        .clear (tmo_clear),
        .enable(tmo_en),
        .expire(tmo_exp)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_DECODE;
            sel_ch <= '0;
        end else begin
            state <= next;
            if (state == ST_DECODE && packet_valid)
                sel_ch <= datain;
        end
    end

    // Count follows the pulse by one edge; saturates rather than wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_pulse <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            drop_pulse <= (next == ST_DROP) && (state != ST_DROP);
            if (drop_pulse && drop_cnt != '1)
                drop_cnt <= drop_cnt + DCNT_W'(1);
        end
    end

    always_comb begin
        detect_add    = (state == ST_DECODE);
        lfd_state     = (state == ST_LOAD_FIRST);
        ld_state      = (state == ST_LOAD_DATA);
        laf_state     = (state == ST_LOAD_AFTER_FULL);
        full_state    = (state == ST_FIFO_FULL);
        rst_int_reg   = (state == ST_CHECK_PARITY);
        drop_state    = (state == ST_DROP);
        write_enb_reg = (state == ST_LOAD_DATA) || (state == ST_LOAD_AFTER_FULL) ||
                        (state == ST_LOAD_PARITY);
        busy          = (state != ST_DECODE) && (state != ST_LOAD_DATA);
        ch_active     = (state == ST_LOAD_FIRST) || (state == ST_LOAD_DATA) ||
                        (state == ST_LOAD_PARITY) || (state == ST_FIFO_FULL) ||
                        (state == ST_LOAD_AFTER_FULL) || (state == ST_CHECK_PARITY);
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_wsel
        assign write_sel[i] = ch_active && (32'(sel_ch) == i);
    end

endmodule
